// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 16x16 register file: two one-entry writeback buffers
// (ALU, MEM), round-robin grant with oldest-first ordering for same-register writes.
module rf_write_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_reg,
  input  logic [15:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_reg,
  input  logic [15:0] mem_data,
  output logic        WriteReg,
  output logic [3:0]  DstReg,
  output logic [15:0] DstData,
  output logic [15:0] busy_mask
);

  logic        hvAlu, hvMem;
  logic [3:0]  hregAlu, hregMem;
  logic [15:0] hdataAlu, hdataMem;
  logic        rr;   // 0: ALU preferred next
  logic        old;  // 1: MEM entry is older
  logic        grantAlu, grantMem;
  logic        loadAlu, loadMem;
  logic        bothDiffer;

  assign bothDiffer = hvAlu && hvMem && (hregAlu != hregMem);

  always_comb begin
    grantAlu = 1'b0;
    grantMem = 1'b0;
    if (!rst) begin
      if (hvAlu && hvMem) begin
        if (hregAlu == hregMem) begin
          grantMem = old;
          grantAlu = !old;
        end else begin
          grantAlu = !rr;
          grantMem = rr;
        end
      end else begin
        grantAlu = hvAlu;
        grantMem = hvMem;
      end
    end
  end

  assign alu_ready = !rst && (!hvAlu || grantAlu);
  assign mem_ready = !rst && (!hvMem || grantMem);

  // Register-0 writes are handshaken but never buffered.
  assign loadAlu = alu_valid && alu_ready && (alu_reg != '0);
  assign loadMem = mem_valid && mem_ready && (mem_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hvAlu    <= 1'b0;
      hvMem    <= 1'b0;
      hregAlu  <= '0;
      hregMem  <= '0;
      hdataAlu <= '0;
      hdataMem <= '0;
      rr       <= 1'b0;
      old      <= 1'b0;
    end else begin
      hvAlu <= loadAlu || (hvAlu && !grantAlu);
      hvMem <= loadMem || (hvMem && !grantMem);
      if (loadAlu) begin
        hregAlu  <= alu_reg;
        hdataAlu <= alu_data;
      end
      if (loadMem) begin
        hregMem  <= mem_reg;
        hdataMem <= mem_data;
      end
      if (bothDiffer)
        rr <= grantAlu;
      // An entry loaded next to a surviving peer is the younger one.
      if (loadAlu && loadMem)
        old <= 1'b1;
      else if (loadAlu && hvMem && !grantMem)
        old <= 1'b1;
      else if (loadMem && hvAlu && !grantAlu)
        old <= 1'b0;
    end
  end

  always_comb begin
    WriteReg = grantAlu || grantMem;
    DstReg   = '0;
    DstData  = '0;
    if (grantAlu) begin
      DstReg  = hregAlu;
      DstData = hdataAlu;
    end else if (grantMem) begin
      DstReg  = hregMem;
      DstData = hdataMem;
    end
  end

  always_comb begin
    busy_mask = '0;
    if (!rst) begin
      if (hvAlu) busy_mask[hregAlu] = 1'b1;
      if (hvMem) busy_mask[hregMem] = 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a small register-file model on the write port.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_reg;
  logic [15:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [3:0]  mem_reg;
  logic [15:0] mem_data;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [15:0] busy_mask;

  int total = 0;
  int bad   = 0;

  logic [15:0] rf [16];

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData), .busy_mask(busy_mask)
  );

  always @(posedge clk)
    if (WriteReg) rf[DstReg] <= DstData;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_reg = '0; alu_data = '0; mem_reg = '0; mem_data = '0;
  endtask

  // write port packed as {WriteReg, DstReg, DstData}
  function automatic logic [31:0] wp();
    return {11'b0, WriteReg, DstReg, DstData};
  endfunction

  function automatic logic [31:0] wexp(input logic [3:0] r, input logic [15:0] d);
    return {11'b0, 1'b1, r, d};
  endfunction

  int ai, mi;
  logic expAr, expMr;
  int it;

  initial begin
    rst = 1'b1;
    alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 16'h1234;
    mem_valid = 1'b1; mem_reg = 4'd2; mem_data = 16'h5678;

    // reset held 3 cycles with valids high
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", {30'b0, alu_ready, mem_ready}, 32'h0);
      check("rst_write", wp(), 32'h0);
      check("rst_busy", busy_mask, 32'h0);
    end
    rst = 1'b0;
    idle();
    #1;
    check("post_rst_ready", {30'b0, alu_ready, mem_ready}, 32'h3);
    tick();

    // single ALU write
    alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 16'hBEEF;
    tick();
    idle();
    #1;
    check("single_port", wp(), wexp(4'd5, 16'hBEEF));
    check("single_busy", busy_mask, 32'h0020);
    tick();
    check("single_busy_clr", busy_mask, 32'h0);
    check("single_idle", wp(), 32'h0);
    check("single_rf5", rf[5], 32'hBEEF);

    // contention, distinct registers, from a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'h1111;
    mem_valid = 1'b1; mem_reg = 4'd4; mem_data = 16'h2222;
    tick();
    idle();
    #1;
    check("cont_first", wp(), wexp(4'd3, 16'h1111));
    check("cont_ready1", {30'b0, alu_ready, mem_ready}, 32'h2);
    check("cont_busy1", busy_mask, 32'h0018);
    tick();
    check("cont_second", wp(), wexp(4'd4, 16'h2222));
    check("cont_busy2", busy_mask, 32'h0010);
    tick();
    check("cont_idle", wp(), 32'h0);
    check("cont_rf", {rf[3], rf[4]}, 32'h1111_2222);

    // same-register ordering: MEM is older
    alu_valid = 1'b1; alu_reg = 4'd7; alu_data = 16'hAAAA;
    mem_valid = 1'b1; mem_reg = 4'd7; mem_data = 16'hBBBB;
    tick();
    idle();
    #1;
    check("same_first", wp(), wexp(4'd7, 16'hBBBB));
    check("same_busy1", busy_mask, 32'h0080);
    tick();
    check("same_second", wp(), wexp(4'd7, 16'hAAAA));
    check("same_busy2", busy_mask, 32'h0080);
    tick();
    check("same_busy_clr", busy_mask, 32'h0);
    check("same_rf7", rf[7], 32'hAAAA);

    // R0 discard
    mem_valid = 1'b1; mem_reg = 4'd0; mem_data = 16'hFFFF;
    #1;
    check("r0_ready0", {31'b0, mem_ready}, 32'h1);
    tick();
    idle();
    #1;
    check("r0_write", wp(), 32'h0);
    check("r0_busy", busy_mask, 32'h0);
    check("r0_ready1", {31'b0, mem_ready}, 32'h1);
    tick();

    // streaming, distinct register sets, starting with rr=0
    rst = 1'b1; tick(); rst = 1'b0;
    ai = 0; mi = 0;
    for (int k = 0; k < 20; k++) begin
      alu_valid = 1'b1; alu_reg = 4'(1 + ai % 7); alu_data = 16'hA000 + 16'(ai);
      mem_valid = 1'b1; mem_reg = 4'(8 + mi % 8); mem_data = 16'hB000 + 16'(mi);
      #1;
      expAr = (k == 0) || (k % 2 == 1);
      expMr = (k == 0) || (k % 2 == 0);
      check("strm_ready", {30'b0, alu_ready, mem_ready}, {30'b0, expAr, expMr});
      if (k == 0) begin
        check("strm_w0", wp(), 32'h0);
      end else if (k % 2 == 1) begin
        it = (k - 1) / 2;
        check("strm_alu", wp(), wexp(4'(1 + it % 7), 16'hA000 + 16'(it)));
      end else begin
        it = (k - 2) / 2;
        check("strm_mem", wp(), wexp(4'(8 + it % 8), 16'hB000 + 16'(it)));
      end
      if (expAr) ai++;
      if (expMr) mi++;
      tick();
    end

    // mid-stream reset drops both pending entries
    idle();
    rst = 1'b1;
    #1;
    check("mid_rst_write", wp(), 32'h0);
    check("mid_rst_ready", {30'b0, alu_ready, mem_ready}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_post_write", wp(), 32'h0);
    check("mid_post_busy", busy_mask, 32'h0);
    check("mid_post_ready", {30'b0, alu_ready, mem_ready}, 32'h3);
    tick();
    check("mid_post_idle", wp(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
